// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register (LANES x WIDTH packed lanes)
// with valid/ready handshake, synchronous flush (bubble insert) and 1-cycle latency.
// Optional feature: define PIPE_REG_SKID_EN to add a second (skid) entry, making
// in_ready a pure register output; otherwise a single entry with combinational in_ready.
module pipe_stage_reg #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned LANES       = 6,
    parameter bit          ZERO_BUBBLE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [1:0]             occupancy
);
    localparam int unsigned DW = LANES * WIDTH;

    logic [DW-1:0] main_q, main_d;
    logic          valid_q, valid_d;
    logic [1:0]    occ_q, occ_d;
    logic          in_fire_c, out_fire_c;

    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = valid_q & out_ready;

    assign out_data  = main_q;
    assign out_valid = valid_q;
    assign occupancy = occ_q;

`ifdef PIPE_REG_SKID_EN
    logic [DW-1:0] skid_q, skid_d;
    logic          skid_valid_q, skid_valid_d;

    // Registered ready: only a full skid entry blocks upstream.
    assign in_ready = ~skid_valid_q;

    // Next state for main + skid entries; flush wins, then drain/refill, then accept.
    always_comb begin
        main_d       = main_q;
        valid_d      = valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            if (ZERO_BUBBLE) begin
                main_d = '0;
                skid_d = '0;
            end
        end else if (out_fire_c) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no beat can arrive this cycle
                main_d       = skid_q;
                skid_valid_d = 1'b0;
                if (ZERO_BUBBLE) begin
                    skid_d = '0;
                end
            end else if (in_fire_c) begin
                main_d  = in_data;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
                if (ZERO_BUBBLE) begin
                    main_d = '0;
                end
            end
        end else if (in_fire_c) begin
            if (valid_q) begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end else begin
                main_d  = in_data;
                valid_d = 1'b1;
            end
        end
        occ_d = {1'b0, valid_d} + {1'b0, skid_valid_d};
    end

    // Skid entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    // Single entry: accept when empty or when the held beat leaves this cycle.
    assign in_ready = ~valid_q | out_ready;

    // Next state for the single entry; flush wins, then accept, then drain.
    always_comb begin
        main_d  = main_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
            if (ZERO_BUBBLE) begin
                main_d = '0;
            end
        end else if (in_fire_c) begin
            main_d  = in_data;
            valid_d = 1'b1;
        end else if (out_fire_c) begin
            valid_d = 1'b0;
            if (ZERO_BUBBLE) begin
                main_d = '0;
            end
        end
        occ_d = {1'b0, valid_d};
    end
`endif

    // Main entry and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q  <= '0;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            main_q  <= main_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: two instances (ZERO_BUBBLE=1 and 0) share stimulus and
// are compared against a queue-based model of held beats. Honours PIPE_REG_SKID_EN.
module tb_pipe_stage_reg;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 6;
    localparam int unsigned DW    = WIDTH * LANES;
`ifdef PIPE_REG_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          rdy_zb, rdy_hold, ov_zb, ov_hold;
    logic [DW-1:0] od_zb, od_hold;
    logic [1:0]    occ_zb, occ_hold;

    int checks = 0;
    int errors = 0;

    // model: beats held by the stage, oldest first, and last shown data per instance
    logic [DW-1:0]    mq[$];
    logic [DW-1:0]    last_zb, last_hold;
    logic             exp_ready, fired;
    logic             obs_ready_zb, obs_ready_hold;
    logic [WIDTH-1:0] seen[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(WIDTH), .LANES(LANES), .ZERO_BUBBLE(1'b1)) u_zb (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_zb),
        .in_data(in_data), .out_valid(ov_zb), .out_ready(out_ready), .out_data(od_zb),
        .occupancy(occ_zb)
    );

    pipe_stage_reg #(.WIDTH(WIDTH), .LANES(LANES), .ZERO_BUBBLE(1'b0)) u_hold (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_hold),
        .in_data(in_data), .out_valid(ov_hold), .out_ready(out_ready), .out_data(od_hold),
        .occupancy(occ_hold)
    );

    function automatic logic [DW-1:0] mk(input logic [WIDTH-1:0] l0);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 1; k < int'(LANES); k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        v[WIDTH-1:0] = l0;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] pc(input int i);
        logic [WIDTH-1:0] b;
        b = 32'h0040_0000;
        return b + WIDTH'(4 * i);
    endfunction

    // One clock: apply inputs, sample ready/out_fire mid-cycle, advance model after the edge.
    task automatic tick(input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
        flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        exp_ready = (CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || ordy);
        fired = iv && exp_ready;
        @(negedge clk);
        obs_ready_zb   = rdy_zb;
        obs_ready_hold = rdy_hold;
        if (ov_zb && ordy) seen.push_back(od_zb[WIDTH-1:0]);
        @(posedge clk);
        #1;
        if (f) mq.delete();
        else begin
            if (mq.size() > 0 && ordy) void'(mq.pop_front());
            if (fired) mq.push_back(d);
        end
        last_zb   = (mq.size() > 0) ? mq[0] : '0;
        last_hold = (mq.size() > 0) ? mq[0] : last_hold;
    endtask

    task automatic model_clear();
        mq.delete();
        last_zb = '0;
        last_hold = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ov_zb, ov_hold, occ_zb, occ_hold} !== 6'b0) begin
            errors++; $display("FAIL reset_state valid %b/%b occ %0d/%0d want 0", ov_zb, ov_hold, occ_zb, occ_hold);
        end
        checks++;
        if (od_zb !== '0 || od_hold !== '0 || rdy_zb !== 1'b1) begin
            errors++; $display("FAIL reset_data data %h ready %b want 0/1", od_zb, rdy_zb);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        // mid-stream asynchronous reset
        tick(1'b0, 1'b1, mk(pc(0)), 1'b0);
        checks++;
        if (ov_zb !== 1'b1 || ov_hold !== 1'b1) begin
            errors++; $display("FAIL pre_reset_valid got %b/%b want 1", ov_zb, ov_hold);
        end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ov_zb !== 1'b0 || ov_hold !== 1'b0 || od_zb !== '0 || od_hold !== '0) begin
            errors++; $display("FAIL async_reset valid %b/%b data %h/%h want 0", ov_zb, ov_hold, od_zb, od_hold);
        end
        checks++;
        if (occ_zb !== 2'd0 || rdy_zb !== 1'b1 || rdy_hold !== 1'b1) begin
            errors++; $display("FAIL async_reset_ready occ %0d ready %b/%b want 0/1", occ_zb, rdy_zb, rdy_hold);
        end
        model_clear();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, mk(pc(i)), 1'b1);
            checks++;
            if (ov_zb !== 1'b1 || od_zb[WIDTH-1:0] !== pc(i) || od_zb !== mq[0]) begin
                errors++; $display("FAIL stream_%0d valid %b lane0 %h want 1 %h", i, ov_zb, od_zb[WIDTH-1:0], pc(i));
            end
            checks++;
            if (obs_ready_zb !== 1'b1) begin
                errors++; $display("FAIL stream_ready_%0d got %b want 1", i, obs_ready_zb);
            end
        end
    endtask

    task automatic test_drain_hold();
        tick(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (ov_hold !== 1'b0 || od_hold[WIDTH-1:0] !== pc(2)) begin
            errors++; $display("FAIL drain_hold valid %b lane0 %h want 0 %h", ov_hold, od_hold[WIDTH-1:0], pc(2));
        end
        checks++;
        if (ov_zb !== 1'b0 || od_zb !== '0 || occ_zb !== 2'd0) begin
            errors++; $display("FAIL drain_zero valid %b data %h occ %0d want 0", ov_zb, od_zb, occ_zb);
        end
    endtask

    task automatic test_stall();
        int idx;
        int n;
        idx = 0;
        seen.delete();
        tick(1'b0, 1'b1, mk(pc(idx)), 1'b1);
        if (fired) idx++;
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 1'b1, mk(pc(idx)), 1'b0);
            if (fired) idx++;
            checks++;
            if (ov_zb !== 1'b1 || od_zb[WIDTH-1:0] !== pc(0)) begin
                errors++; $display("FAIL stall_hold_%0d valid %b lane0 %h want 1 %h", c, ov_zb, od_zb[WIDTH-1:0], pc(0));
            end
        end
        checks++;
        if (occ_zb !== 2'(CAP) || rdy_zb !== 1'b0 || rdy_hold !== 1'b0) begin
            errors++; $display("FAIL stall_occ occ %0d ready %b want %0d 0", occ_zb, rdy_zb, CAP);
        end
        n = 0;
        while ((idx < 3 || mq.size() > 0) && n < 20) begin
            tick(1'b0, idx < 3, mk(pc(idx)), 1'b1);
            if (fired) idx++;
            n++;
        end
        checks++;
        if (seen.size() != 3 || seen[0] !== pc(0) || seen[1] !== pc(1) || seen[2] !== pc(2)) begin
            errors++; $display("FAIL stall_order got %0d beats want 3 in order", seen.size());
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] x;
        x = mk(pc(2));
        tick(1'b0, 1'b1, x, 1'b0);
        tick(1'b1, 1'b1, mk(32'h0040_000C), 1'b1);
        checks++;
        if (ov_zb !== 1'b0 || occ_zb !== 2'd0 || ov_hold !== 1'b0 || occ_hold !== 2'd0) begin
            errors++; $display("FAIL flush_state valid %b occ %0d want 0 0", ov_zb, occ_zb);
        end
        checks++;
        if (od_zb !== '0 || od_hold !== x) begin
            errors++; $display("FAIL flush_data zb %h hold %h want 0 %h", od_zb, od_hold, x);
        end
        seen.delete();
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (seen.size() != 0 || ov_zb !== 1'b0) begin
            errors++; $display("FAIL flush_discard got %0d beats want 0", seen.size());
        end
    endtask

    task automatic test_flush_full();
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b1, mk(pc(c)), 1'b0);
        checks++;
        if (occ_zb !== 2'(CAP)) begin
            errors++; $display("FAIL full_occ got %0d want %0d", occ_zb, CAP);
        end
        tick(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (ov_zb !== 1'b0 || occ_zb !== 2'd0 || rdy_zb !== 1'b1 || od_zb !== '0) begin
            errors++; $display("FAIL flush_full valid %b occ %0d ready %b want 0 0 1", ov_zb, occ_zb, rdy_zb);
        end
    endtask

    task automatic test_random();
        logic          ev;
        logic [1:0]    eocc;
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                 mk(WIDTH'($urandom)), $urandom_range(0, 2) != 0);
            ev   = mq.size() > 0;
            eocc = 2'(mq.size());
            checks++;
            if ({ov_zb, ov_hold, occ_zb, occ_hold} !== {ev, ev, eocc, eocc}) begin
                errors++; $display("FAIL rand_state_%0d valid %b/%b occ %0d/%0d want %b %0d", c, ov_zb, ov_hold, occ_zb, occ_hold, ev, eocc);
            end
            checks++;
            if (od_zb !== last_zb || od_hold !== last_hold) begin
                errors++; $display("FAIL rand_data_%0d zb %h hold %h want %h %h", c, od_zb, od_hold, last_zb, last_hold);
            end
            checks++;
            if (obs_ready_zb !== exp_ready || obs_ready_hold !== exp_ready) begin
                errors++; $display("FAIL rand_ready_%0d got %b/%b want %b", c, obs_ready_zb, obs_ready_hold, exp_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_drain_hold();
        test_stall();
        test_flush();
        test_flush_full();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
